reduction_accumulator_int: RTL and testbench

Integer cross-phit accumulator placed directly downstream of the integer adder-tree reduction unit. Each cycle the tree collapses one phit into a single dwidth_double partial sum. This block adds a programmed number of those partial sums into one message-level result. It then holds the result on a valid/ready output handshake until the consumer accepts it.

---
 rtl/reduction_accumulator_int.sv | 119 +++++++++++
 tb/tb_reduction_accumulator_int.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduction_accumulator_int.sv
// Cross-phit integer accumulator: sums num_beats partial sums from the adder tree
// and holds the message result on a valid/ready output until it is accepted.
module reduction_accumulator_int #(
    parameter int DWIDTH = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Output handshake: out_data is held constant while out_valid is high, and
    // the result is consumed on any rising edge where out_valid && out_ready.
    state_t             state_q, state_d;
    logic [DWIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DWIDTH-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [DWIDTH-1:0]  sum;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        sum        = acc_q + in_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    // A beat arriving with the start is dropped and its error wins over the clear.
                    err_d = in_valid;
                    if (num_beats != '0) begin
                        rem_d   = num_beats;
                        state_d = ACC;
                    end else begin
                        out_data_d = '0;
                        state_d    = OUT;
                    end
                end else if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            ACC: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (in_valid) begin
                    acc_d = sum;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        out_data_d = sum;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (start || in_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reduction_accumulator_int.sv
// Bench for reduction_accumulator_int: directed scenarios plus randomized messages,
// with results checked by a scoreboard fed from a message-level sum model.
module tb_reduction_accumulator_int;

    localparam int W = 64;
    localparam int C = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [C-1:0]  num_beats;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    logic          err;
    logic [1:0]    dbg_state;

    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          rdy_random = 1'b0;

    reduction_accumulator_int #(.DWIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .err(err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops an expected result on every accepted output, and checks hold stability
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && out_valid) check("out_data_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    check("result", out_data, exp_q.pop_front());
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = out_valid;
                prev_data = out_data;
            end
        end
    end

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_random) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input logic [C-1:0] n);
        start = 1'b1;
        num_beats = n;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || out_valid) && k < 200) begin
            step();
            k++;
        end
        if (busy || out_valid) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [W-1:0] s;
        logic [W-1:0] d;
        int n;
        rst = 1'b0; start = 1'b0; num_beats = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", W'(busy), 0);
        check("rst_err", W'(err), 0);
        check("rst_state", W'(dbg_state), 0);
        rst = 1'b1;
        step();

        // basic sum
        do_start(4);
        check("start_busy", W'(busy), 1);
        exp_q.push_back(100);
        beat(10); beat(20); beat(30);
        check("acc_no_valid", W'(out_valid), 0);
        beat(40);
        check("basic_valid", W'(out_valid), 1);
        check("basic_busy", W'(busy), 1);
        check("basic_err", W'(err), 0);
        check("basic_data", out_data, 100);
        handshake();
        check("basic_idle_valid", W'(out_valid), 0);
        check("basic_idle_busy", W'(busy), 0);

        // gaps and back-pressure
        do_start(3);
        exp_q.push_back(10);
        beat(5); step(); step();
        beat(-64'sd2); step(); step();
        beat(7);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", W'(out_valid), 1);
            check("bp_data", out_data, 10);
            step();
        end
        handshake();
        check("bp_done", W'(out_valid), 0);

        // wrap-around
        do_start(2);
        exp_q.push_back(1);
        beat(64'hFFFF_FFFF_FFFF_FFFF); beat(2);
        check("wrap_data", out_data, 1);
        check("wrap_err", W'(err), 0);
        handshake();

        // zero length, then back-to-back single beat
        do_start(0);
        exp_q.push_back(0);
        check("zero_valid", W'(out_valid), 1);
        check("zero_data", out_data, 0);
        handshake();
        do_start(1);
        exp_q.push_back(9);
        beat(9);
        check("b2b_data", out_data, 9);
        handshake();
        check("held_after_hs", out_data, 9);

        // violations
        beat(55);
        check("viol_idle_err", W'(err), 1);
        check("viol_idle_valid", W'(out_valid), 0);
        do_start(2);
        check("start_clears_err", W'(err), 0);
        exp_q.push_back(3);
        beat(1); beat(2);
        beat(100);
        check("viol_out_err", W'(err), 1);
        check("viol_out_data", out_data, 3);
        handshake();
        do_start(2);
        exp_q.push_back(9);
        beat(4);
        do_start(7);
        check("viol_acc_err", W'(err), 1);
        check("viol_acc_busy", W'(busy), 1);
        check("viol_acc_valid", W'(out_valid), 0);
        beat(5);
        check("viol_acc_data", out_data, 9);
        handshake();

        // reset mid-operation
        do_start(4);
        beat(11); beat(12);
        rst = 1'b0;
        #1;
        check("midrst_busy", W'(busy), 0);
        check("midrst_valid", W'(out_valid), 0);
        check("midrst_data", out_data, 0);
        check("midrst_err", W'(err), 1'b0);
        check("midrst_state", W'(dbg_state), 0);
        step();
        rst = 1'b1;
        step();
        do_start(1);
        exp_q.push_back(3);
        beat(3);
        check("post_rst_data", out_data, 3);
        handshake();

        // randomized messages with random back-pressure
        rdy_random = 1'b1;
        for (int m = 0; m < 30; m++) begin
            wait_idle();
            n = $urandom_range(0, 6);
            s = '0;
            do_start(C'(n));
            for (int b = 0; b < n; b++) begin
                d = {$urandom, $urandom};
                s = s + d;
                beat(d);
                repeat ($urandom_range(0, 2)) begin
                    if (b != n - 1) step();
                end
            end
            exp_q.push_back(s);
        end
        wait_idle();
        repeat (3) step();
        check("queue_drained", W'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
